// File: rtl/rv32i_pkg.sv
// Shared RV32 datapath definitions: ALU control codes, multiply/divide op
// encodings and the multiply/divide sequencer state type.
package rv32i_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    typedef enum logic [1:0] {
        MD_MUL   = 2'b00,
        MD_MULHU = 2'b01,
        MD_DIVU  = 2'b10,
        MD_REMU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } md_state_e;

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bus between the core and the multiply/divide sequencer.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, op, a, b, input busy, done, result);
    modport slave  (input start, op, a, b, output busy, done, result);
endinterface

// File: rtl/muldiv_seq_dp.sv
// Shift-register datapath for shift-add multiply and restoring divide; the
// adder itself is the shared ALU, so only operand muxing and compares live here.
module muldiv_dp
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_load,
    input  logic            i_run,
    input  logic            i_isDiv,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [XLEN-1:0] i_aluRes,
    output logic [XLEN-1:0] o_aluSrcA,
    output logic [XLEN-1:0] o_aluSrcB,
    output logic [2:0]      o_aluCtrl,
    output logic [XLEN-1:0] o_hiNext,
    output logic [XLEN-1:0] o_loNext
);

    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_m;
    logic [XLEN-1:0] w_rs;
    logic            w_ok;
    logic            w_carry;

    // hi/lo double as R/Q for divide; ALU operands depend only on registered state
    always_comb begin
        w_rs      = {r_hi[XLEN-2:0], r_lo[XLEN-1]};
        w_ok      = r_hi[XLEN-1] | (w_rs >= r_m);
        w_carry   = (i_aluRes < r_hi);
        o_aluSrcA = '0;
        o_aluSrcB = '0;
        o_aluCtrl = ALU_ADD;
        if (i_run) begin
            if (i_isDiv) begin
                o_aluSrcA = w_rs;
                o_aluSrcB = r_m;
                o_aluCtrl = ALU_SUB;
            end else begin
                o_aluSrcA = r_hi;
                o_aluSrcB = r_lo[0] ? r_m : '0;
            end
        end
        if (i_isDiv) begin
            o_hiNext = w_ok ? i_aluRes : w_rs;
            o_loNext = {r_lo[XLEN-2:0], w_ok};
        end else begin
            o_hiNext = {w_carry, i_aluRes[XLEN-1:1]};
            o_loNext = {i_aluRes[0], r_lo[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
            r_m  <= '0;
        end else if (i_load) begin
            r_hi <= '0;
            r_lo <= i_a;
            r_m  <= i_b;
        end else if (i_run) begin
            r_hi <= o_hiNext;
            r_lo <= o_loNext;
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M unsigned multiply/divide sequencer: FSM, iteration counter and result
// register around the shift datapath, borrowing the shared ALU while busy.
module muldiv_seq
    import rv32i_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    muldiv_if.slave         bus,
    output logic [XLEN-1:0] alu_srcA,
    output logic [XLEN-1:0] alu_srcB,
    output logic [2:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_res
);

    md_state_e       r_state;
    md_state_e       w_nextState;
    md_op_e          r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0] r_result;
    logic [XLEN-1:0] w_hiNext;
    logic [XLEN-1:0] w_loNext;
    logic [XLEN-1:0] w_finalRes;
    logic            w_accept;
    logic            w_lastIter;
    logic            w_isDiv;
    logic            w_run;

    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_lastIter  = (r_cnt == CNT_W'(XLEN - 1));
        w_isDiv     = (r_op == MD_DIVU) || (r_op == MD_REMU);
        w_run       = (r_state == RUN);
        unique case (r_op)
            MD_MUL:   w_finalRes = w_loNext;
            MD_MULHU: w_finalRes = w_hiNext;
            MD_DIVU:  w_finalRes = w_loNext;
            default:  w_finalRes = w_hiNext;
        endcase
        case (r_state)
            IDLE, DONE: begin
                w_accept    = bus.start;
                w_nextState = bus.start ? RUN : IDLE;
            end
            RUN:     if (w_lastIter) w_nextState = DONE;
            default: w_nextState = IDLE;
        endcase
    end

    // Result is taken from the datapath's next values so it includes the last iteration
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_op     <= MD_MUL;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_op  <= md_op_e'(bus.op);
                r_cnt <= '0;
            end else if (w_run) begin
                r_cnt <= w_lastIter ? '0 : r_cnt + 1'b1;
                if (w_lastIter) r_result <= w_finalRes;
            end
        end
    end

    muldiv_dp #(.XLEN(XLEN)) u_dp (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_accept),
        .i_run     (w_run),
        .i_isDiv   (w_isDiv),
        .i_a       (bus.a),
        .i_b       (bus.b),
        .i_aluRes  (alu_res),
        .o_aluSrcA (alu_srcA),
        .o_aluSrcB (alu_srcB),
        .o_aluCtrl (alu_ctrl),
        .o_hiNext  (w_hiNext),
        .o_loNext  (w_loNext)
    );

    assign bus.busy   = (r_state == RUN);
    assign bus.done   = (r_state == DONE);
    assign bus.result = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq with a behavioural ALU attached and an
// arithmetic reference model for MUL/MULHU/DIVU/REMU.
module tb_muldiv_seq;

    logic        clk;
    logic        reset;
    logic [31:0] aluSrcA;
    logic [31:0] aluSrcB;
    logic [2:0]  aluCtrl;
    logic [31:0] aluRes;
    int          total;
    int          bad;

    muldiv_if #(.XLEN(32)) bus ();

    muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .alu_srcA (aluSrcA),
        .alu_srcB (aluSrcB),
        .alu_ctrl (aluCtrl),
        .alu_res  (aluRes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The shared ALU as the datapath sees it: add or subtract
    always_comb begin
        aluRes = (aluCtrl == 3'b001) ? (aluSrcA - aluSrcB) : (aluSrcA + aluSrcB);
    end

    function automatic logic [31:0] refModel(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] prod;
        prod = {32'd0, a} * {32'd0, b};
        case (op)
            2'b00:   return prod[31:0];
            2'b01:   return prod[63:32];
            2'b10:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge; holds start for exactly one rising edge
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Starts one operation, follows it to done, and checks latency, busy count,
    // ALU control during the run and the result. Returns in the done cycle.
    task automatic runAndCheck(input string tag, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input int ignoreAt = -1);
        int lat;
        int busyCnt;
        int ctrlErr;
        logic [2:0] expCtrl;
        expCtrl = op[1] ? 3'b001 : 3'b000;
        applyStimulus(op, a, b);
        lat     = 1;
        busyCnt = 0;
        ctrlErr = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busyCnt++;
            if (bus.busy && aluCtrl !== expCtrl) ctrlErr++;
            if (lat == ignoreAt) begin
                bus.start = 1'b1;
                bus.op    = ~op;
                bus.a     = 32'h1234_5678;
                bus.b     = 32'h0000_0003;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        checkOutput({tag, "_latency"}, 32'(lat), 32'd33);
        checkOutput({tag, "_busyCycles"}, 32'(busyCnt), 32'd32);
        checkOutput({tag, "_ctrlErr"}, 32'(ctrlErr), 32'd0);
        checkOutput({tag, "_result"}, bus.result, refModel(op, a, b));
        checkOutput({tag, "_busyInDone"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic checkIdle(input string tag, input logic [31:0] expResult);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(bus.done), 32'd0);
        checkOutput({tag, "_result"}, bus.result, expResult);
        checkOutput({tag, "_srcA"}, aluSrcA, 32'd0);
        checkOutput({tag, "_srcB"}, aluSrcB, 32'd0);
        checkOutput({tag, "_ctrl"}, 32'(aluCtrl), 32'd0);
    endtask

    initial begin
        int doneSeen;
        logic [1:0]  rOp;
        logic [31:0] rA;
        logic [31:0] rB;
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        repeat (2) @(negedge clk);
        checkIdle("reset", 32'd0);
        reset = 1'b0;
        @(negedge clk);

        runAndCheck("mul7x6", 2'b00, 32'd7, 32'd6);
        checkOutput("mul7x6_value", bus.result, 32'h0000_002A);
        @(negedge clk);
        checkIdle("afterDone", 32'h0000_002A);

        runAndCheck("mulhuMax", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checkOutput("mulhuMax_value", bus.result, 32'hFFFF_FFFE);
        runAndCheck("mulMax", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checkOutput("mulMax_value", bus.result, 32'h0000_0001);
        runAndCheck("divu1025", 2'b10, 32'd1025, 32'd1000);
        runAndCheck("remu1025", 2'b11, 32'd1025, 32'd1000);
        checkOutput("remu1025_value", bus.result, 32'd25);
        runAndCheck("divu513", 2'b10, 32'd513, 32'd1000);
        runAndCheck("remu513", 2'b11, 32'd513, 32'd1000);
        runAndCheck("divuByZero", 2'b10, 32'd513, 32'd0);
        checkOutput("divuByZero_value", bus.result, 32'hFFFF_FFFF);
        runAndCheck("remuByZero", 2'b11, 32'd513, 32'd0);
        checkOutput("remuByZero_value", bus.result, 32'h0000_0201);
        @(negedge clk);

        runAndCheck("mulIgnoreStart", 2'b00, 32'd7, 32'd6, 5);
        checkOutput("mulIgnoreStart_value", bus.result, 32'h0000_002A);
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("backToBack_busy", 32'(bus.busy), 32'd1);
        doneSeen = 0;
        for (int i = 2; i <= 40; i++) begin
            @(negedge clk);
            if (bus.done && doneSeen == 0) doneSeen = i;
        end
        checkOutput("backToBack_doneCycle", 32'(doneSeen), 32'd33);
        checkOutput("backToBack_result", bus.result, 32'd14);

        applyStimulus(2'b10, 32'hDEAD_BEEF, 32'd3);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkIdle("midReset", 32'd0);
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) doneSeen++;
        end
        checkOutput("midReset_noDone", 32'(doneSeen), 32'd0);

        for (int n = 0; n < 16; n++) begin
            rOp = 2'($urandom_range(0, 3));
            rA  = $urandom;
            case (n % 4)
                0:       rB = 32'd0;
                1:       rB = $urandom_range(1, 255);
                default: rB = $urandom;
            endcase
            runAndCheck($sformatf("rand%0d", n), rOp, rA, rB);
            if (n % 2 == 1) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for the RV32M unsigned multiply and divide operations. It reuses the shared 32-bit combinational ALU instead of adding a dedicated adder: each iteration drives the ALU operands and control, captures `res` and updates internal shift registers. It sits beside the ALU in the datapath. The ALU input mux selects this block while `busy` is high.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width.
- `CNT_W`, default 6: iteration counter width; must hold XLEN.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `op`  in  2  operation, sampled with `start`: 00 MUL (low word), 01 MULHU (high word), 10 DIVU, 11 REMU.
- `a`  in  XLEN  multiplicand or dividend, sampled with `start`.
- `b`  in  XLEN  multiplier or divisor, sampled with `start`.
- `alu_srcA`  out  XLEN  to ALU `srcA`.
- `alu_srcB`  out  XLEN  to ALU `srcB`.
- `alu_ctrl`  out  3  to ALU `ALUControl`: 000 add, 001 sub.
- `alu_res`  in  XLEN  from ALU `res`.
- `busy`  out  1  high in RUN.
- `done`  out  1  single-cycle pulse in DONE.
- `result`  out  XLEN  final value; valid from DONE and held until the next accepted `start` or `reset`.

## Operation
States and transitions:
- **IDLE**: `start` goes to RUN. Otherwise stay.
- **RUN**: 32 iterations, counter 0..31; counter = 31 goes to DONE.
- **DONE**: `start` goes to RUN (back-to-back accept). Otherwise go to IDLE.

Start capture:
- Latch `op` and the operands.
- MUL: hi = 0, lo = `a`, M = `b`.
- DIV: R = 0, Q = `a`, D = `b`.

Multiply (shift-add), each iteration:
- Drive `alu_srcA` = hi, `alu_srcB` = lo[0] ? M : 0, `alu_ctrl` = 000.
- carry = (`alu_res` < hi) unsigned, computed locally.
- {hi, lo} <= {carry, `alu_res`, lo} >> 1, truncated to 64 bits.

Divide (restoring), each iteration:
- Shifted remainder: Rs = {R[30:0], Q[31]}; msb = R[31].
- Drive `alu_srcA` = Rs, `alu_srcB` = D, `alu_ctrl` = 001.
- ok = msb | (Rs >= D).
- R <= ok ? `alu_res` : Rs.
- Q <= {Q[30:0], ok}.

Result register, written on the RUN to DONE edge: MUL gives lo, MULHU gives hi, DIVU gives Q, REMU gives R.

Boundary conditions:
- Divisor 0 needs no special path. The algorithm yields Q = 0xFFFFFFFF and R = `a`, which meets RISC-V semantics.
- `start` during RUN is ignored; operands are not re-sampled.
- `reset` in any state gives IDLE and clears all registers, with no `done`. It has priority over `start` in the same cycle.
- In IDLE and DONE, `alu_srcA` = `alu_srcB` = 0 and `alu_ctrl` = 000.

## Timing
- Reset values: `busy` 0, `done` 0, `result` 0, `alu_srcA` 0, `alu_srcB` 0, `alu_ctrl` 000, state IDLE, counter 0.
- Latency: `start` sampled at edge N. RUN covers cycles N+1..N+32. `done` = 1 and `result` valid in cycle N+33.
- Throughput: one operation per 33 cycles when restarted from DONE.
- ALU outputs are a combinational function of registered state only; there is no path from `alu_res` to `alu_src*`.
- `alu_res` is consumed in the same cycle. The ALU path must close in one cycle.
- `busy` and `done` are registered (state-decoded) and are never high together.

## Structure
Shared package `rv32i_pkg`:
- ALU control constants `ALU_ADD` = 3'b000 and `ALU_SUB` = 3'b001, shared with the ALU decoder.
- MD op encodings `MD_MUL`, `MD_MULHU`, `MD_DIVU`, `MD_REMU`.
- State enum: IDLE, RUN, DONE.

Sub-modules:
- One natural sub-module, `muldiv_dp`: hi/lo (R/Q) shift registers, carry/ok compare, and the operand mux.
- `muldiv_seq` keeps the FSM, the counter and `result`.
- Bench instantiates `muldiv_seq` with the real ALU connected.

## Test plan
- MUL `a`=7, `b`=6: start at cycle 0 gives `busy` for cycles 1–32, `done` at cycle 33 with `result` = 0x0000002A.
- MULHU and MUL with `a` = `b` = 0xFFFFFFFF: `result` = 0xFFFFFFFE and 0x00000001 respectively.
- DIVU and REMU with `a`=1025, `b`=1000: `result` = 1, then 25. With `a`=513, `b`=1000: 0, then 513.
- DIVU and REMU with `a`=513, `b`=0: `result` = 0xFFFFFFFF, then 0x00000201.
- `start` with different operands at cycle 5 of a running MUL 7×6: ignored, `result` still 0x2A. New `start` in the DONE cycle: `busy` the next cycle and a second `done` 33 cycles later.
- `reset` at cycle 10 of a DIVU: next cycle `busy` = 0, `result` = 0, ALU outputs 0/000, and no `done` in the following 40 cycles.
